hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32 core. Detects load-use and

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle.
// The slave side belongs to the hazard unit; the master side belongs to the pipeline.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memRead;
    logic              ex_branch_taken;
    logic              dmem_busy;
    logic              stall_clr;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              ctrl_flush;
    logic              pipe_hold;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memRead,
        input  ex_branch_taken, dmem_busy, stall_clr,
        output pc_write, ifid_write, ifid_flush, ctrl_flush,
        output pipe_hold, stall_cnt
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memRead,
        output ex_branch_taken, dmem_busy, stall_clr,
        input  pc_write, ifid_write, ifid_flush, ctrl_flush,
        input  pipe_hold, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
// Covers load-use, taken-branch flush and data-memory wait, plus a stall counter.
module hazard_ctrl #(
    parameter int REG_AW         = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam int FCW = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t           state, state_n, eff;
    logic [FCW-1:0]   flush_cnt, flush_cnt_n;
    logic             ret_flush, ret_flush_n;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;
    logic             pc_w, ifid_w, ifid_f, ctrl_f, hold;

    assign load_use = bus.ex_memRead
                    && (bus.ex_rd != REG_AW'(0))
                    && ((bus.ex_rd == bus.id_rs1)
                        || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    // Leaving MEMWAIT, the cycle runs under the state that was interrupted.
    always_comb begin
        eff = RUN;
        case (state)
            FLUSH:   eff = FLUSH;
            MEMWAIT: eff = ret_flush ? FLUSH : RUN;
            default: eff = RUN;
        endcase
    end

    always_comb begin
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        ifid_f      = 1'b0;
        ctrl_f      = 1'b0;
        hold        = 1'b0;
        state_n     = RUN;
        flush_cnt_n = flush_cnt;
        ret_flush_n = ret_flush;
        if (bus.dmem_busy) begin
            pc_w        = 1'b0;
            ifid_w      = 1'b0;
            hold        = 1'b1;
            state_n     = MEMWAIT;
            ret_flush_n = (eff == FLUSH);
        end else if (eff == FLUSH) begin
            ifid_f      = 1'b1;
            ctrl_f      = 1'b1;
            ret_flush_n = 1'b0;
            flush_cnt_n = flush_cnt - FCW'(1);
            state_n     = (flush_cnt_n == '0) ? RUN : FLUSH;
        end else begin
            ret_flush_n = 1'b0;
            if (bus.ex_branch_taken) begin
                ifid_f = 1'b1;
                ctrl_f = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    state_n     = FLUSH;
                    flush_cnt_n = FCW'(BRANCH_PENALTY - 1);
                end
            end else if (load_use) begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                ctrl_f = 1'b1;
            end
        end
        if (rst) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            ifid_f = 1'b1;
            ctrl_f = 1'b1;
            hold   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            ret_flush <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            ret_flush <= ret_flush_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.stall_clr) begin
            cnt_q <= '0;
        end else if (!pc_w && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_write   = pc_w;
    assign bus.ifid_write = ifid_w;
    assign bus.ifid_flush = ifid_f;
    assign bus.ctrl_flush = ctrl_f;
    assign bus.pipe_hold  = hold;
    assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// outs = {pc_write, ifid_write, ifid_flush, ctrl_flush, pipe_hold}
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_cnt;
    logic [4:0] outs;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) bus ();

    hazard_ctrl #(
        .REG_AW(5),
        .BRANCH_PENALTY(3),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign outs = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                   bus.ctrl_flush, bus.pipe_hold};

    task automatic idle();
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_memRead      = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.dmem_busy       = 1'b0;
        bus.stall_clr       = 1'b0;
    endtask

    task automatic set_lu();
        bus.ex_memRead = 1'b1;
        bus.ex_rd      = 5'd5;
        bus.id_rs1     = 5'd5;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk);
        checks++;
        if (outs !== 5'b00110) begin
            errors++;
            $display("FAIL rst_outs got %b exp %b", outs, 5'b00110);
        end
        checks++;
        if (bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_cnt got %0d exp 0", bus.stall_cnt);
        end
        nxt();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL run_idle got %b exp %b", outs, 5'b11000);
        end
        nxt();
        set_lu();
        nxt();
        idle();
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL pre_rst_cnt got %0d exp 1", bus.stall_cnt);
        end
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if (outs !== 5'b11110) begin
            errors++;
            $display("FAIL flush_pre_rst got %b exp %b", outs, 5'b11110);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00110) begin
            errors++;
            $display("FAIL async_rst got %b exp %b", outs, 5'b00110);
        end
        checks++;
        if (bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_rst_cnt got %0d exp 0", bus.stall_cnt);
        end
        nxt();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL post_rst_run got %b exp %b", outs, 5'b11000);
        end
        exp_cnt = 4'd0;
    endtask

    task automatic test_load_use();
        nxt();
        set_lu();
        @(negedge clk);
        checks++;
        if (outs !== 5'b00010) begin
            errors++;
            $display("FAIL lu_stall got %b exp %b", outs, 5'b00010);
        end
        nxt();
        idle();
        exp_cnt = 4'd1;
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL lu_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL lu_one_cycle got %b exp %b", outs, 5'b11000);
        end
        nxt();
        bus.ex_memRead = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL lu_rd0 got %b exp %b", outs, 5'b11000);
        end
        nxt();
        idle();
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL lu_rd0_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_rs2();
        bus.ex_memRead  = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.id_rs1      = 5'd3;
        bus.id_rs2      = 5'd5;
        bus.id_uses_rs2 = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL rs2_unused got %b exp %b", outs, 5'b11000);
        end
        nxt();
        bus.id_uses_rs2 = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 5'b00010) begin
            errors++;
            $display("FAIL rs2_used got %b exp %b", outs, 5'b00010);
        end
        nxt();
        idle();
        exp_cnt = 4'd2;
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rs2_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_branch();
        bus.ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b11110) begin
                errors++;
                $display("FAIL br_flush%0d got %b exp %b", i, outs, 5'b11110);
            end
            nxt();
            idle();
            set_lu();
        end
        idle();
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL br_end got %b exp %b", outs, 5'b11000);
        end
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL br_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
        nxt();
    endtask

    task automatic test_memwait();
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 5'b11110) begin
            errors++;
            $display("FAIL mw_br got %b exp %b", outs, 5'b11110);
        end
        nxt();
        idle();
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b00001) begin
                errors++;
                $display("FAIL mw_hold%0d got %b exp %b", i, outs, 5'b00001);
            end
            nxt();
        end
        bus.dmem_busy = 1'b0;
        exp_cnt = 4'd6;
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mw_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b11110) begin
                errors++;
                $display("FAIL mw_resume%0d got %b exp %b", i, outs, 5'b11110);
            end
            nxt();
        end
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL mw_end got %b exp %b", outs, 5'b11000);
        end
        nxt();
        bus.ex_branch_taken = 1'b1;
        bus.dmem_busy       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b00001) begin
                errors++;
                $display("FAIL brbusy_hold%0d got %b exp %b", i, outs, 5'b00001);
            end
            nxt();
        end
        bus.dmem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 5'b11110) begin
                errors++;
                $display("FAIL brbusy_flush%0d got %b exp %b", i, outs, 5'b11110);
            end
            nxt();
            idle();
        end
        @(negedge clk);
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL brbusy_end got %b exp %b", outs, 5'b11000);
        end
        exp_cnt = 4'd8;
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL brbusy_cnt got %0d exp %0d", bus.stall_cnt, exp_cnt);
        end
        nxt();
    endtask

    task automatic test_saturate();
        set_lu();
        repeat (20) begin
            @(negedge clk);
            nxt();
        end
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt got %0d exp 15", bus.stall_cnt);
        end
        bus.stall_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 5'b00010) begin
            errors++;
            $display("FAIL sat_stall got %b exp %b", outs, 5'b00010);
        end
        nxt();
        checks++;
        if (bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_cnt got %0d exp 0", bus.stall_cnt);
        end
        bus.stall_clr = 1'b0;
        nxt();
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL post_clr_cnt got %0d exp 1", bus.stall_cnt);
        end
        idle();
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_load_use();
        test_rs2();
        test_branch();
        test_memwait();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
